// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch sequencer. Holds the PC and reads words from a synchronous
//   instruction memory (read data returns one cycle after imem_rd_en). Each
//   fetched instruction is handed to the decoder over a valid/ready handshake.
//   Fetching stops for good once the decoder accepts a HALT_OP instruction;
//   only reset leaves the halted state.
//
//   Ports
//     clk, reset       rising-edge clock, synchronous active-high reset
//     start            leaves IDLE and begins fetching at PC
//     imem_rd_en       memory read strobe (high only while fetching)
//     imem_addr        read address (PC during a read, otherwise 0)
//     imem_rdata       read data, valid the cycle after imem_rd_en
//     instr_out        registered instruction to the decoder
//     opcode_out       top 4 bits of instr_out
//     pc_out           address instr_out was fetched from
//     instr_valid      instr_out/opcode_out/pc_out valid
//     instr_ready      decoder accepts; transfer on valid && ready
//     redirect_valid   load redirect_pc and drop any in-flight fetch
//     redirect_pc      redirect target
//     halted           high once a HALT instruction has been accepted
//     fetch_cnt        (FETCH_PERF_EN) accepted instructions, saturating
//     stall_cnt        (FETCH_PERF_EN) valid cycles without ready, saturating
//
//   Optional feature: define FETCH_PERF_EN to add the two performance counters.

module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'b1111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [3:0]         opcode_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_HALTED
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               accept;
    logic               redir;

    assign accept = (state == S_VALID) && instr_ready;
    // Redirects only matter while a fetch is in progress
    assign redir  = redirect_valid &&
                    ((state == S_FETCH) || (state == S_WAIT) || (state == S_VALID));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = redir ? S_FETCH : S_WAIT;
            S_WAIT:   state_nxt = redir ? S_FETCH : S_VALID;
            S_VALID: begin
                // An accepted HALT wins over a simultaneous redirect
                if (accept) begin
                    state_nxt = (opcode_out == HALT_OP) ? S_HALTED : S_FETCH;
                end else if (redir) begin
                    state_nxt = S_FETCH;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        imem_rd_en  = (state == S_FETCH);
        imem_addr   = (state == S_FETCH) ? pc : '0;
        instr_valid = (state == S_VALID);
        halted      = (state == S_HALTED);
    end

    assign instr_out  = instr_q;
    assign opcode_out = instr_q[INSTR_W-1 -: 4];
    assign pc_out     = pc_q;

    // PC and instruction register; a redirect in WAIT drops the returning data
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            if (redir) begin
                pc <= redirect_pc;
            end else if (state == S_WAIT) begin
                pc      <= pc + ADDR_W'(1);
                instr_q <= imem_rdata;
                pc_q    <= pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if ((state == S_VALID) && !instr_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
